// File: rtl/rtx_pixel_dither.sv
// ---------------------------------------------------------------------------
// rtx_pixel_dither
//
// Purpose:
//   Converts the ray tracer's RGB888 pixel stream into RGB565 for the DRAM
//   frame buffer's camera-side write port. It applies a 4x4 ordered (Bayer)
//   dither whose phase rotates once per completed frame, so the dither
//   pattern also varies over time. Pixels outside the active area are
//   dropped and counted. Fixed two-cycle latency with no backpressure.
//
// Ports:
//   clk         single clock (ray tracer / camera domain)
//   rst         asynchronous active-high reset
//   dither_en   1 = Bayer dither, 0 = plain truncation (sampled per pixel)
//   valid_in    one-cycle strobe, pixel ready on r/g/b/h/v inputs
//   r_in, g_in, b_in  RGB888 colour
//   h_in, v_in  pixel column / row
//   valid_out   one-cycle strobe to the frame buffer
//   pixel_out   {r5, g6, b5}
//   h_out, v_out  coordinates aligned with pixel_out
//   frame_idx   completed-frame counter, wraps 255 -> 0
//   drop_count  out-of-bounds pixel count, saturates at 0xFFFF
// ---------------------------------------------------------------------------
module rtx_pixel_dither #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dither_en,
    input  logic        valid_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    input  logic [10:0] h_in,
    input  logic [9:0]  v_in,
    output logic        valid_out,
    output logic [15:0] pixel_out,
    output logic [10:0] h_out,
    output logic [9:0]  v_out,
    output logic [7:0]  frame_idx,
    output logic [15:0] drop_count
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    // 4x4 Bayer matrix, indexed [y][x].
    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] t;
        case ({y, x})
            4'b00_00: t = 4'd0;
            4'b00_01: t = 4'd8;
            4'b00_10: t = 4'd2;
            4'b00_11: t = 4'd10;
            4'b01_00: t = 4'd12;
            4'b01_01: t = 4'd4;
            4'b01_10: t = 4'd14;
            4'b01_11: t = 4'd6;
            4'b10_00: t = 4'd3;
            4'b10_01: t = 4'd11;
            4'b10_10: t = 4'd1;
            4'b10_11: t = 4'd9;
            4'b11_00: t = 4'd15;
            4'b11_01: t = 4'd7;
            4'b11_10: t = 4'd13;
            default:  t = 4'd5;
        endcase
        return t;
    endfunction

    // Adds a dither offset to one channel and clamps at full scale so that
    // bright colours never wrap around to black.
    function automatic logic [7:0] add_sat(input logic [7:0] c, input logic [2:0] t);
        logic [8:0] sum;
        sum = {1'b0, c} + {6'd0, t};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_r_q, s1_r_d;
    logic [7:0]  s1_g_q, s1_g_d;
    logic [7:0]  s1_b_q, s1_b_d;
    logic [10:0] s1_h_q, s1_h_d;
    logic [9:0]  s1_v_q, s1_v_d;
    logic        s1_den_q, s1_den_d;
    logic [3:0]  s1_t_q, s1_t_d;
    logic [7:0]  frame_idx_q, frame_idx_d;
    logic [15:0] drop_count_q, drop_count_d;

    // Stage 2 (output) state
    logic        valid_out_q, valid_out_d;
    logic [15:0] pixel_out_q, pixel_out_d;
    logic [10:0] h_out_q, h_out_d;
    logic [9:0]  v_out_q, v_out_d;

    logic        in_bounds;
    logic [1:0]  bx, by;
    logic [2:0]  t_rb, t_g;
    logic [7:0]  r_sat, g_sat, b_sat;

    // Stage 1: bounds test, Bayer lookup with the current frame phase, and
    // the frame / drop counters. Out-of-bounds pixels never set the stage
    // valid, so the stage valid doubles as the in-bounds flag downstream.
    always_comb begin
        in_bounds    = (h_in < H_LIM) && (v_in < V_LIM);
        bx           = h_in[1:0] + frame_idx_q[1:0];
        by           = v_in[1:0] + frame_idx_q[1:0];
        s1_valid_d   = valid_in && in_bounds;
        s1_r_d       = s1_r_q;
        s1_g_d       = s1_g_q;
        s1_b_d       = s1_b_q;
        s1_h_d       = s1_h_q;
        s1_v_d       = s1_v_q;
        s1_den_d     = s1_den_q;
        s1_t_d       = s1_t_q;
        frame_idx_d  = frame_idx_q;
        drop_count_d = drop_count_q;
        if (valid_in) begin
            s1_r_d   = r_in;
            s1_g_d   = g_in;
            s1_b_d   = b_in;
            s1_h_d   = h_in;
            s1_v_d   = v_in;
            s1_den_d = dither_en;
            s1_t_d   = bayer(by, bx);
            if (!in_bounds) begin
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end else if (h_in == H_LAST && v_in == V_LAST) begin
                frame_idx_d = frame_idx_q + 8'd1;
            end
        end
    end

    // Stage 2: R/B take half the threshold and G a quarter, matching the
    // differing number of bits each channel discards. Output registers only
    // load on a valid pixel so they hold the last pixel otherwise.
    always_comb begin
        t_rb        = s1_den_q ? s1_t_q[3:1] : 3'd0;
        t_g         = s1_den_q ? {1'b0, s1_t_q[3:2]} : 3'd0;
        r_sat       = add_sat(s1_r_q, t_rb);
        g_sat       = add_sat(s1_g_q, t_g);
        b_sat       = add_sat(s1_b_q, t_rb);
        valid_out_d = s1_valid_q;
        pixel_out_d = pixel_out_q;
        h_out_d     = h_out_q;
        v_out_d     = v_out_q;
        if (s1_valid_q) begin
            pixel_out_d = {r_sat[7:3], g_sat[7:2], b_sat[7:3]};
            h_out_d     = s1_h_q;
            v_out_d     = s1_v_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_r_q       <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
            s1_h_q       <= '0;
            s1_v_q       <= '0;
            s1_den_q     <= 1'b0;
            s1_t_q       <= '0;
            frame_idx_q  <= '0;
            drop_count_q <= '0;
            valid_out_q  <= 1'b0;
            pixel_out_q  <= '0;
            h_out_q      <= '0;
            v_out_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_r_q       <= s1_r_d;
            s1_g_q       <= s1_g_d;
            s1_b_q       <= s1_b_d;
            s1_h_q       <= s1_h_d;
            s1_v_q       <= s1_v_d;
            s1_den_q     <= s1_den_d;
            s1_t_q       <= s1_t_d;
            frame_idx_q  <= frame_idx_d;
            drop_count_q <= drop_count_d;
            valid_out_q  <= valid_out_d;
            pixel_out_q  <= pixel_out_d;
            h_out_q      <= h_out_d;
            v_out_q      <= v_out_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign pixel_out  = pixel_out_q;
    assign h_out      = h_out_q;
    assign v_out      = v_out_q;
    assign frame_idx  = frame_idx_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rtx_pixel_dither.sv
// ---------------------------------------------------------------------------
// tb_rtx_pixel_dither
//
// Purpose:
//   Self-checking bench for rtx_pixel_dither: a table of single pixels with
//   hand-computed RGB565 results, plus hand-written sequences for
//   back-to-back pixels, frame completion and wrap, drop-counter
//   saturation, and reset killing an in-flight pixel.
// ---------------------------------------------------------------------------
module tb_rtx_pixel_dither;

    typedef struct {
        logic        den;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [10:0] h;
        logic [9:0]  v;
        logic        exp_valid;
        logic [15:0] exp_pix;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        dither_en;
    logic        valid_in;
    logic [7:0]  r_in, g_in, b_in;
    logic [10:0] h_in;
    logic [9:0]  v_in;
    logic        valid_out;
    logic [15:0] pixel_out;
    logic [10:0] h_out;
    logic [9:0]  v_out;
    logic [7:0]  frame_idx;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int exp_drops = 0;
    vec_t vecs[10];

    rtx_pixel_dither #(.H_ACTIVE(1280), .V_ACTIVE(720)) dut (
        .clk        (clk),
        .rst        (rst),
        .dither_en  (dither_en),
        .valid_in   (valid_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .h_in       (h_in),
        .v_in       (v_in),
        .valid_out  (valid_out),
        .pixel_out  (pixel_out),
        .h_out      (h_out),
        .v_out      (v_out),
        .frame_idx  (frame_idx),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_pixel(input logic den, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic [10:0] h, input logic [9:0] v);
        dither_en = den;
        r_in      = r;
        g_in      = g;
        b_in      = b;
        h_in      = h;
        v_in      = v;
        valid_in  = 1'b1;
    endtask

    // Sends one isolated pixel and checks the strobe timing and payload.
    task automatic apply_stimulus(input vec_t vc, input string name);
        @(posedge clk); #1;
        drive_pixel(vc.den, vc.r, vc.g, vc.b, vc.h, vc.v);
        if (!vc.exp_valid) exp_drops++;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_output({name, "_early"}, 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        check_output({name, "_valid"}, 32'(valid_out), 32'(vc.exp_valid));
        if (vc.exp_valid) begin
            check_output({name, "_pix"}, 32'(pixel_out), 32'(vc.exp_pix));
            check_output({name, "_h"},   32'(h_out),     32'(vc.h));
            check_output({name, "_v"},   32'(v_out),     32'(vc.v));
        end
        @(posedge clk); #1;
        check_output({name, "_late"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        dither_en = 1'b0;
        valid_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0; h_in = '0; v_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("rst_valid", 32'(valid_out),  32'd0);
        check_output("rst_pix",   32'(pixel_out),  32'd0);
        check_output("rst_frame", 32'(frame_idx),  32'd0);
        check_output("rst_drops", 32'(drop_count), 32'd0);

        // den, r, g, b, h, v, exp_valid, exp_pix  (frame_idx = 0 throughout)
        vecs[0] = '{1'b1, 8'h07, 8'h02, 8'h07, 11'd0,    10'd0,   1'b1, 16'h0000}; // T=0
        vecs[1] = '{1'b1, 8'h07, 8'h02, 8'h07, 11'd1,    10'd0,   1'b1, 16'h0821}; // T=8
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 11'd1,    10'd0,   1'b1, 16'hFFFF}; // saturate
        vecs[3] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 11'd1,    10'd0,   1'b1, 16'hFFFF};
        vecs[4] = '{1'b0, 8'h12, 8'h34, 8'h56, 11'd3,    10'd3,   1'b1, 16'h11AA}; // truncation
        vecs[5] = '{1'b1, 8'h12, 8'h34, 8'h56, 11'd3,    10'd3,   1'b1, 16'h11AB}; // T=5
        vecs[6] = '{1'b1, 8'h0F, 8'h03, 8'hF9, 11'd2,    10'd1,   1'b1, 16'h103F}; // T=14, B sat
        vecs[7] = '{1'b1, 8'h03, 8'h02, 8'h03, 11'd1279, 10'd0,   1'b1, 16'h0821}; // T=10
        vecs[8] = '{1'b1, 8'h55, 8'h55, 8'h55, 11'd1280, 10'd0,   1'b0, 16'h0000}; // h OOB
        vecs[9] = '{1'b1, 8'h55, 8'h55, 8'h55, 11'd0,    10'd720, 1'b0, 16'h0000}; // v OOB

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end
        check_output("drops_after_table", 32'(drop_count), 32'(exp_drops));
        check_output("frame_after_table", 32'(frame_idx),  32'd0);

        // Back-to-back pixels: each emerges on its own cycle, in order.
        @(posedge clk); #1;
        drive_pixel(1'b1, 8'h07, 8'h02, 8'h07, 11'd0, 10'd0);
        @(posedge clk); #1;
        drive_pixel(1'b1, 8'h07, 8'h02, 8'h07, 11'd1, 10'd0);
        check_output("b2b_n1_valid", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_output("b2b_n2_valid", 32'(valid_out), 32'd1);
        check_output("b2b_n2_pix",   32'(pixel_out), 32'h0000);
        check_output("b2b_n2_h",     32'(h_out),     32'd0);
        @(posedge clk); #1;
        check_output("b2b_n3_valid", 32'(valid_out), 32'd1);
        check_output("b2b_n3_pix",   32'(pixel_out), 32'h0821);
        check_output("b2b_n3_h",     32'(h_out),     32'd1);
        @(posedge clk); #1;
        check_output("b2b_n4_valid", 32'(valid_out), 32'd0);
        check_output("b2b_hold_pix", 32'(pixel_out), 32'h0821);

        // Last active pixel completes the frame; next pixel uses phase 1.
        apply_stimulus('{1'b1, 8'h00, 8'h00, 8'h00, 11'd1279, 10'd719, 1'b1, 16'h0000}, "frame_end");
        check_output("frame_inc", 32'(frame_idx), 32'd1);
        apply_stimulus('{1'b1, 8'h07, 8'h00, 8'h00, 11'd0, 10'd0, 1'b1, 16'h0800}, "phase1");

        // 255 more frame-end pixels wrap the counter 1 -> 0.
        @(posedge clk); #1;
        drive_pixel(1'b1, 8'h00, 8'h00, 8'h00, 11'd1279, 10'd719);
        repeat (255) @(posedge clk);
        #1 valid_in = 1'b0;
        check_output("frame_wrap", 32'(frame_idx), 32'd0);

        // Drop counter runs up to one below saturation, then pins at 0xFFFF.
        @(posedge clk); #1;
        drive_pixel(1'b1, 8'h00, 8'h00, 8'h00, 11'd1280, 10'd0);
        repeat (65532) @(posedge clk);
        #1 valid_in = 1'b0;
        check_output("drops_near_sat", 32'(drop_count), 32'd65534);
        @(posedge clk); #1;
        valid_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 valid_in = 1'b0;
        check_output("drops_sat", 32'(drop_count), 32'hFFFF);

        // Reset one cycle after accepting a pixel kills it in flight.
        @(posedge clk); #1;
        drive_pixel(1'b1, 8'hAA, 8'hBB, 8'hCC, 11'd5, 10'd6);
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        check_output("rst_kill_valid", 32'(seen),       32'd0);
        check_output("rst2_pix",       32'(pixel_out),  32'd0);
        check_output("rst2_h",         32'(h_out),      32'd0);
        check_output("rst2_v",         32'(v_out),      32'd0);
        check_output("rst2_frame",     32'(frame_idx),  32'd0);
        check_output("rst2_drops",     32'(drop_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtx_pixel_dither.md
Name: rtx_pixel_dither

Overview:
- Sits between the ray tracer's per-pixel output (color8 r/g/b, h/v count, done strobe) and the DRAM frame buffer's camera-side write port.
- Converts 24-bit RGB888 pixels to RGB565 using a 4x4 ordered (Bayer) dither. The Bayer phase rotates per frame, giving temporal dither.
- Drops pixels whose coordinates fall outside the active area.
- Tracks frame completion and counts dropped pixels.

Parameters:
- H_ACTIVE, 1280, active horizontal pixels; h_in >= H_ACTIVE is out of bounds.
- V_ACTIVE, 720, active vertical lines; v_in >= V_ACTIVE is out of bounds.

Ports:
- clk  in  1  single clock (ray tracer / camera domain)
- rst  in  1  reset; asynchronous, active-high
- dither_en  in  1  1 = Bayer dither, 0 = plain truncation. Sampled with each input pixel.
- valid_in  in  1  one-cycle strobe; the ray tracer has a pixel ready
- r_in, g_in, b_in  in  8 each  RGB888 colour
- h_in  in  11  pixel column
- v_in  in  10  pixel row
- valid_out  out  1  one-cycle strobe to the frame buffer
- pixel_out  out  16  {r5,g6,b5}
- h_out  out  11  column aligned with pixel_out
- v_out  out  10  row aligned with pixel_out
- frame_idx  out  8  completed-frame counter, wraps 255->0
- drop_count  out  16  out-of-bounds pixels dropped, saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0; both pipeline stage valids cleared. Assertion at any time kills in-flight pixels; nothing emerges after reset releases.
- No backpressure. A new pixel may be accepted every cycle.
- Pipeline, fixed latency 2 cycles:
  - Input at cycle N -> valid_out high at cycle N+2 for exactly one cycle.
  - h/v propagate unchanged.
- Stage 1: register colour, h, v, dither_en, in-bounds flag, and Bayer threshold T.
  - Index x = (h_in[1:0] + frame_idx[1:0]) mod 4; y = (v_in[1:0] + frame_idx[1:0]) mod 4.
  - Bayer rows, indexed [y][x]: y0 = 0,8,2,10; y1 = 12,4,14,6; y2 = 3,11,1,9; y3 = 15,7,13,5.
- Stage 2: channel arithmetic in 9 bits.
  - R and B: add T>>1 (0..7), saturate to 255, take [7:3].
  - G: add T>>2 (0..3), saturate to 255, take [7:2].
  - dither_en = 0: thresholds forced to 0 (pure truncation).
- Out of bounds (h_in >= H_ACTIVE or v_in >= V_ACTIVE):
  - The pixel never produces valid_out.
  - drop_count increments at stage 1, saturating at 0xFFFF.
- frame_idx:
  - Increments in the cycle an in-bounds pixel with h_in == H_ACTIVE-1 and v_in == V_ACTIVE-1 is accepted at stage 1.
  - The new value applies to Bayer phase from the next accepted pixel onward.
- valid_in low: stage data registers may hold stale values, but stage valids clear, so valid_out is 0.
- Back-to-back pixels: each produces its own output in order. There is no merging and no reordering.
- Output registers hold their last value while valid_out is low.

Test Plan:
- Reset, then idle 10 cycles -> valid_out, pixel_out, frame_idx, drop_count all 0.
- frame_idx = 0, dither_en = 1; pixels (7,2,7) at (h0,v0), then (h1,v0) on consecutive cycles.
  - First pixel: T = 0 -> pixel_out = 0x0000, valid_out at N+2.
  - Second pixel: T = 8 -> R = (7+4)>>3 = 1, G = (2+2)>>2 = 1, B = 1 -> pixel_out = 0x0821 at N+3.
- Pixel (255,255,255) at (h1,v0), dither_en = 1 -> saturation, pixel_out = 0xFFFF. Same pixel with dither_en = 0 -> 0xFFFF.
- Pixels at (1280,0) and (0,720) -> no valid_out, drop_count = 2. Preload drop_count near saturation -> it stays at 0xFFFF.
- In-bounds pixel at (1279,719) -> frame_idx goes 0 -> 1.
  - Next pixel (7,0,0) at (h0,v0): Bayer[1][1] = 4, so R = (7+2)>>3 = 1 -> pixel_out = 0x0800.
- Assert rst one cycle after valid_in -> valid_out never asserts for that pixel; all outputs read 0.
